// File: rtl/vga_pkg.sv
// Shared timing constants, pixel formats and colour conversion
// for the frame buffer scan-out path.
package vga_pkg;

  localparam int VGA_H_VIS  = 640;
  localparam int VGA_H_FP   = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP   = 48;
  localparam int VGA_H_TOT  =
    VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_VIS  = 480;
  localparam int VGA_V_FP   = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP   = 33;
  localparam int VGA_V_TOT  =
    VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int FB_W_DEF   = 320;
  localparam int FB_H_DEF   = 240;
  localparam int FB_DATA_W  = 16;
  localparam int FB_ADDR_W  = 17;

  localparam int CNT_W      = 10;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Keep the top bits of each channel.
  function automatic rgb444_t rgb444(input rgb565_t p);
    rgb444_t c;
    c.r = p.r[4:1];
    c.g = p.g[5:2];
    c.b = p.b[4:1];
    return c;
  endfunction

endpackage

// File: rtl/fb_scanout_if.sv
// Read port A of the dual-port frame buffer, seen from
// the scan-out side (master) and the memory side (slave).
interface fb_scanout_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 16
);

  logic              en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] dout;

  modport master (
    output en,
    output addr,
    input  dout
  );

  modport slave (
    input  en,
    input  addr,
    output dout
  );

endinterface

// File: rtl/vga_timing.sv
// Raster counters and the raw blanking, sync and frame-start
// conditions derived from them.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VIS  = VGA_H_VIS,
  parameter int H_FP   = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP   = VGA_H_BP,
  parameter int V_VIS  = VGA_V_VIS,
  parameter int V_FP   = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP   = VGA_V_BP
) (
  input  logic             clk_pix,
  input  logic             rst,
  output logic [CNT_W-2:0] col,
  output logic             visible,
  output logic             hs_raw,
  output logic             vs_raw,
  output logic             fs_raw,
  output logic             row_step,
  output logic             frame_wrap
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] HV  = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] HS0 = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] HS1 =
    CNT_W'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] HL  = CNT_W'(H_TOT - 1);

  localparam logic [CNT_W-1:0] VV  = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] VS0 = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] VS1 =
    CNT_W'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [CNT_W-1:0] VL  = CNT_W'(V_TOT - 1);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_last;
  logic             v_last;

  assign h_last = (h_cnt == HL);
  assign v_last = (v_cnt == VL);

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign visible = (h_cnt < HV) && (v_cnt < VV);

  assign hs_raw = !((h_cnt >= HS0) && (h_cnt <= HS1));
  assign vs_raw = !((v_cnt >= VS0) && (v_cnt <= VS1));

  assign fs_raw = (h_cnt == '0) && (v_cnt == VV);

  // Odd lines close a doubled line pair.
  assign row_step   = h_last && v_cnt[0] && (v_cnt < VV);
  assign frame_wrap = h_last && v_last;

  assign col = h_cnt[CNT_W-1:1];

endmodule

// File: rtl/fb_scanout.sv
// Frame buffer scan-out: 2x upscaled fetch, 3-stage aligned
// pipeline to RGB444 VGA pins and a frame-start pulse.
module fb_scanout
  import vga_pkg::*;
#(
  parameter int W      = FB_W_DEF,
  parameter int H      = FB_H_DEF,
  parameter int DATA_W = FB_DATA_W,
  parameter int ADDR_W = FB_ADDR_W,
  parameter int H_VIS  = VGA_H_VIS,
  parameter int H_FP   = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP   = VGA_H_BP,
  parameter int V_VIS  = VGA_V_VIS,
  parameter int V_FP   = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP   = VGA_V_BP
) (
  input  logic         clk_pix,
  input  logic         rst,
  fb_scanout_if.master fb,
  output logic [3:0]   vga_r,
  output logic [3:0]   vga_g,
  output logic [3:0]   vga_b,
  output logic         vga_hs,
  output logic         vga_vs,
  output logic         vga_de,
  output logic         frame_start
);

  if ((W * H > (1 << ADDR_W)) || (DATA_W < 16))
  begin : g_cfg_chk
    $error("fb_scanout: buffer does not fit ports");
  end

  localparam logic [ADDR_W-1:0] ROW_INC = ADDR_W'(W);

  logic [CNT_W-2:0]  col;
  logic              visible;
  logic              hs_raw;
  logic              vs_raw;
  logic              fs_raw;
  logic              row_step;
  logic              frame_wrap;

  logic [ADDR_W-1:0] row_base;

  logic [1:0]        de_d;
  logic [1:0]        hs_d;
  logic [1:0]        vs_d;
  logic [1:0]        fs_d;

  rgb444_t           px;

  vga_timing #(
    .H_VIS  (H_VIS),
    .H_FP   (H_FP),
    .H_SYNC (H_SYNC),
    .H_BP   (H_BP),
    .V_VIS  (V_VIS),
    .V_FP   (V_FP),
    .V_SYNC (V_SYNC),
    .V_BP   (V_BP)
  ) u_timing (
    .clk_pix    (clk_pix),
    .rst        (rst),
    .col        (col),
    .visible    (visible),
    .hs_raw     (hs_raw),
    .vs_raw     (vs_raw),
    .fs_raw     (fs_raw),
    .row_step   (row_step),
    .frame_wrap (frame_wrap)
  );

  // Running line offset replaces a row * W multiply.
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      row_base <= '0;
    end else if (frame_wrap) begin
      row_base <= '0;
    end else if (row_step) begin
      row_base <= row_base + ROW_INC;
    end
  end

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      fb.en   <= 1'b0;
      fb.addr <= '0;
    end else begin
      fb.en <= visible;
      if (visible) begin
        fb.addr <= row_base + ADDR_W'(col);
      end
    end
  end

  // Two stages here plus the output register match the
  // fetch plus memory latency.
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      de_d <= '0;
      fs_d <= '0;
      hs_d <= '1;
      vs_d <= '1;
    end else begin
      de_d <= {de_d[0], visible};
      fs_d <= {fs_d[0], fs_raw};
      hs_d <= {hs_d[0], hs_raw};
      vs_d <= {vs_d[0], vs_raw};
    end
  end

  assign px = rgb444(rgb565_t'(fb.dout[15:0]));

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_de      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      vga_r       <= de_d[1] ? px.r : 4'h0;
      vga_g       <= de_d[1] ? px.g : 4'h0;
      vga_b       <= de_d[1] ? px.b : 4'h0;
      vga_hs      <= hs_d[1];
      vga_vs      <= vs_d[1];
      vga_de      <= de_d[1];
      frame_start <= fs_d[1];
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: default-timing instance for line,
// address and colour checks, small-timing instance for frames.
module tb_fb_scanout;

  localparam int BW  = 8;
  localparam int BH  = 6;
  localparam int BHV = 16;
  localparam int BHF = 2;
  localparam int BHS = 3;
  localparam int BHB = 3;
  localparam int BVV = 12;
  localparam int BVF = 2;
  localparam int BVS = 2;
  localparam int BVB = 3;
  localparam int BHT = BHV + BHF + BHS + BHB;
  localparam int BVT = BVV + BVF + BVS + BVB;
  localparam int BFR = BHT * BVT;

  typedef struct packed {
    logic        en;
    logic [16:0] addr;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
  } pins_t;

  typedef struct {
    logic [15:0] word;
    logic        de;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
  } cvec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  fb_scanout_if fa ();
  fb_scanout_if fbb ();

  logic [3:0] ar, ag, ab;
  logic       ahs, avs, ade, afs;
  logic [3:0] br, bg, bb;
  logic       bhs, bvs, bde, bfs;

  fb_scanout dut_a (
    .clk_pix     (clk),
    .rst         (rst_a),
    .fb          (fa),
    .vga_r       (ar),
    .vga_g       (ag),
    .vga_b       (ab),
    .vga_hs      (ahs),
    .vga_vs      (avs),
    .vga_de      (ade),
    .frame_start (afs)
  );

  fb_scanout #(
    .W (BW), .H (BH),
    .H_VIS (BHV), .H_FP (BHF), .H_SYNC (BHS), .H_BP (BHB),
    .V_VIS (BVV), .V_FP (BVF), .V_SYNC (BVS), .V_BP (BVB)
  ) dut_b (
    .clk_pix     (clk),
    .rst         (rst_b),
    .fb          (fbb),
    .vga_r       (br),
    .vga_g       (bg),
    .vga_b       (bb),
    .vga_hs      (bhs),
    .vga_vs      (bvs),
    .vga_de      (bde),
    .frame_start (bfs)
  );

  logic        a_const;
  logic [15:0] a_word;
  logic [15:0] memb [BW*BH];

  always @(posedge clk) begin
    if (a_const) fa.dout <= a_word;
    else if (fa.en) fa.dout <= fa.addr[15:0];
  end

  always @(posedge clk) begin
    if (fbb.en) begin
      if (fbb.addr < 17'(BW*BH)) fbb.dout <= memb[fbb.addr[5:0]];
      else fbb.dout <= 16'hDEAD;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] got,
                     logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Reference: raster position from elapsed cycles, pixel
  // from the doubled image coordinates.
  function automatic pins_t model_b(int k, logic [16:0] last);
    pins_t p;
    int x, y;
    logic [15:0] w;
    p.en = 1'b0; p.addr = last;
    p.r = 4'h0; p.g = 4'h0; p.b = 4'h0;
    p.de = 1'b0; p.hs = 1'b1; p.vs = 1'b1; p.fs = 1'b0;
    if (k >= 1) begin
      x = (k - 1) % BHT;
      y = ((k - 1) / BHT) % BVT;
      if (x < BHV && y < BVV) begin
        p.en = 1'b1;
        p.addr = 17'((y / 2) * BW + x / 2);
      end
    end
    if (k >= 3) begin
      x = (k - 3) % BHT;
      y = ((k - 3) / BHT) % BVT;
      p.hs = !(x >= BHV + BHF && x < BHV + BHF + BHS);
      p.vs = !(y >= BVV + BVF && y < BVV + BVF + BVS);
      p.fs = (x == 0 && y == BVV);
      if (x < BHV && y < BVV) begin
        p.de = 1'b1;
        w = memb[(y / 2) * BW + x / 2];
        p.r = w[15:12]; p.g = w[10:7]; p.b = w[4:1];
      end
    end
    return p;
  endfunction

  int          kb = 0;
  logic [16:0] last_b = '0;
  int          fs_times[$];
  int          vs_runs[$];
  int          vs_cur = 0;

  task automatic step_b();
    pins_t want, got;
    @(negedge clk);
    if (rst_b) begin
      kb = 0;
      last_b = '0;
    end else begin
      kb++;
    end
    want = model_b(rst_b ? 0 : kb, last_b);
    last_b = want.addr;
    got.en = fbb.en; got.addr = fbb.addr;
    got.r = br; got.g = bg; got.b = bb;
    got.de = bde; got.hs = bhs; got.vs = bvs; got.fs = bfs;
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL pins_b k=%0d rst=%0b: got %h want %h",
               kb, rst_b, got, want);
    end
    if (bfs && !rst_b) fs_times.push_back(kb);
    if (!bvs) vs_cur++;
    else if (vs_cur > 0) begin
      vs_runs.push_back(vs_cur);
      vs_cur = 0;
    end
  endtask

  task automatic chk_line(string name, int q[$], int base);
    int bad;
    bad = 0;
    chk({name, "_len"}, q.size(), 640);
    for (int i = 0; i < q.size() && i < 640; i++)
      if (q[i] != base + i / 2) bad++;
    chk({name, "_vals"}, bad, 0);
  endtask

  int    lq0[$], lq1[$], lq2[$];
  int    hs_fall[$], hs_runs[$], de_runs[$];
  int    hs_cur, de_cur;
  logic  hs_prev;
  logic  hit;
  cvec_t cv[7];

  initial begin
    cv[0] = '{16'hF800, 1'b1, 4'hF, 4'h0, 4'h0};
    cv[1] = '{16'h07E0, 1'b1, 4'h0, 4'hF, 4'h0};
    cv[2] = '{16'h001F, 1'b1, 4'h0, 4'h0, 4'hF};
    cv[3] = '{16'hFFFF, 1'b1, 4'hF, 4'hF, 4'hF};
    cv[4] = '{16'h1234, 1'b1, 4'h1, 4'h4, 4'hA};
    cv[5] = '{16'h8410, 1'b1, 4'h8, 4'h8, 4'h8};
    cv[6] = '{16'hFFFF, 1'b0, 4'h0, 4'h0, 4'h0};

    for (int i = 0; i < BW * BH; i++) memb[i] = 16'($urandom);
    a_const = 1'b0;
    a_word  = 16'h0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;

    // Default timing: reset hold and release.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_hold", {ahs, avs, ar, ag, ab, fa.en, ade},
          {1'b1, 1'b1, 12'h0, 1'b0, 1'b0});
    end
    rst_a = 1'b0;

    hs_cur = 0; de_cur = 0; hs_prev = 1'b1;
    for (int k = 1; k <= 2500; k++) begin
      @(negedge clk);
      if (k == 1) chk("first_fetch", {fa.en, fa.addr},
                      {1'b1, 17'd0});
      if (k == 2) chk("de_early", ade, 1'b0);
      if (k == 3) chk("de_first", ade, 1'b1);
      if (fa.en) begin
        if ((k - 1) / 800 == 0) lq0.push_back(int'(fa.addr));
        else if ((k - 1) / 800 == 1) lq1.push_back(int'(fa.addr));
        else if ((k - 1) / 800 == 2) lq2.push_back(int'(fa.addr));
      end
      if (!ahs) begin
        if (hs_prev) hs_fall.push_back(k);
        hs_cur++;
      end else if (hs_cur > 0) begin
        hs_runs.push_back(hs_cur);
        hs_cur = 0;
      end
      hs_prev = ahs;
      if (ade) de_cur++;
      else if (de_cur > 0) begin
        de_runs.push_back(de_cur);
        de_cur = 0;
      end
    end

    chk_line("line0", lq0, 0);
    chk_line("line1", lq1, 0);
    chk_line("line2", lq2, 320);
    chk("hs_runs", hs_runs.size(), 3);
    foreach (hs_runs[i]) chk("hs_low", hs_runs[i], 96);
    chk("hs_falls", hs_fall.size(), 3);
    if (hs_fall.size() >= 2)
      chk("line_period", hs_fall[1] - hs_fall[0], 800);
    chk("de_runs", de_runs.size(), 3);
    foreach (de_runs[i]) chk("de_len", de_runs[i], 640);

    // Colour conversion and blank forcing.
    for (int i = 0; i < 7; i++) begin
      a_const = 1'b1;
      a_word = cv[i].word;
      hit = 1'b0;
      for (int n = 1; n <= 2000 && !hit; n++) begin
        @(negedge clk);
        if (n >= 4 && ade == cv[i].de) begin
          hit = 1'b1;
          chk($sformatf("colour%0d", i), {ar, ag, ab},
              {cv[i].r, cv[i].g, cv[i].b});
        end
      end
      chk($sformatf("colour%0d_found", i), hit, 1'b1);
    end

    // Small timing: free-running frames against the model.
    step_b();
    rst_b = 1'b0;
    for (int i = 0; i < 2 * BFR + 60; i++) begin
      step_b();
      if (kb == 1 + (BVV - 1) * BHT + BHV - 1)
        chk("last_line_end", fbb.addr, 17'(BW * BH - 1));
    end
    chk("fs_count", fs_times.size(), 2);
    if (fs_times.size() >= 2) begin
      chk("fs_first", fs_times[0], 3 + BVV * BHT);
      chk("frame_period", fs_times[1] - fs_times[0], BFR);
    end
    chk("vs_runs", vs_runs.size(), 2);
    foreach (vs_runs[i]) chk("vs_low", vs_runs[i], 2 * BHT);

    // Reset in the middle of a visible line.
    hit = 1'b0;
    for (int i = 0; i < BFR && !hit; i++) begin
      step_b();
      if (kb % BFR == 8 * BHT + 10) hit = 1'b1;
    end
    chk("midreset_reached", hit, 1'b1);
    rst_b = 1'b1;
    for (int i = 0; i < 3; i++) step_b();
    rst_b = 1'b0;
    fs_times.delete();
    step_b();
    chk("restart_addr", {fbb.en, fbb.addr}, {1'b1, 17'd0});
    while (kb < BHT + 1) step_b();
    chk("row_pair_addr", {fbb.en, fbb.addr}, {1'b1, 17'd0});
    while (kb < BVV * BHT + 5) step_b();
    chk("fs_after_reset", fs_times.size(), 1);
    if (fs_times.size() >= 1)
      chk("fs_after_reset_k", fs_times[0], 3 + BVV * BHT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
